// File: rtl/operand_fetch_if.sv
// Decode/regfile/writeback/execute signal bundle for the operand-fetch stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface operand_fetch_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
);
  logic            dec_valid;
  logic            dec_ready;
  logic [PC_W-1:0] dec_pc;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rs1_en;
  logic            dec_rs2_en;
  logic [4:0]      dec_rs1_addr;
  logic [4:0]      dec_rs2_addr;
  logic            dec_rd_we;
  logic [4:0]      dec_rd_addr;
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            kill_en;
  logic [4:0]      kill_addr;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [PC_W-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic            ex_rd_we;
  logic [4:0]      ex_rd_addr;
  logic [31:0]     sb_pending;

  modport master (
    output dec_valid, dec_pc, dec_imm, dec_rs1_en, dec_rs2_en, dec_rs1_addr,
           dec_rs2_addr, dec_rd_we, dec_rd_addr, rf_rs1_data, rf_rs2_data,
           wb_en, wb_addr, wb_data, kill_en, kill_addr, flush, ex_ready,
    input  dec_ready, rf_rs1_addr, rf_rs2_addr, ex_valid, ex_pc, ex_imm,
           ex_rs1_val, ex_rs2_val, ex_rd_we, ex_rd_addr, sb_pending
  );

  modport slave (
    input  dec_valid, dec_pc, dec_imm, dec_rs1_en, dec_rs2_en, dec_rs1_addr,
           dec_rs2_addr, dec_rd_we, dec_rd_addr, rf_rs1_data, rf_rs2_data,
           wb_en, wb_addr, wb_data, kill_en, kill_addr, flush, ex_ready,
    output dec_ready, rf_rs1_addr, rf_rs2_addr, ex_valid, ex_pc, ex_imm,
           ex_rs1_val, ex_rs2_val, ex_rd_we, ex_rd_addr, sb_pending
  );
endinterface

// File: rtl/operand_fetch.sv
// RV64I decode->execute stage: register read with writeback bypass, a one-entry
// output slot, and a 32-entry scoreboard that stalls RAW/WAW hazards.
module operand_fetch #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input logic           clk,
  input logic           rst,
  operand_fetch_if.slave bus
);

  // Writeback bypass hit on a register; x0 never matches.
  function automatic logic wb_match(input logic en, input logic [4:0] addr,
                                    input logic [4:0] r);
    return en && (addr == r) && (r != 5'd0);
  endfunction

  logic [31:0]     pend_r;
  logic [31:0]     pend_next_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic            ex_valid_r;
  logic [PC_W-1:0] ex_pc_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [XLEN-1:0] ex_rs1_val_r;
  logic [XLEN-1:0] ex_rs2_val_r;
  logic            ex_rd_we_r;
  logic [4:0]      ex_rd_addr_r;
  logic            hazard_s;
  logic            dec_ready_s;
  logic            accept_s;
  logic            rd_write_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

  // Hazard detection, handshake and operand resolution.
  always_comb begin
    rd_write_s = bus.dec_rd_we && (bus.dec_rd_addr != 5'd0);
    hazard_s =
        (bus.dec_rs1_en && (bus.dec_rs1_addr != 5'd0) && pend_r[bus.dec_rs1_addr]
         && !wb_match(bus.wb_en, bus.wb_addr, bus.dec_rs1_addr))
      | (bus.dec_rs2_en && (bus.dec_rs2_addr != 5'd0) && pend_r[bus.dec_rs2_addr]
         && !wb_match(bus.wb_en, bus.wb_addr, bus.dec_rs2_addr))
      | (rd_write_s && pend_r[bus.dec_rd_addr]
         && !wb_match(bus.wb_en, bus.wb_addr, bus.dec_rd_addr));
    dec_ready_s = !rst && !bus.flush && !hazard_s && (!ex_valid_r || bus.ex_ready);
    accept_s    = bus.dec_valid && dec_ready_s;

    // Regfile data is stale during its own write cycle, so wb_data wins.
    rs1_val_s = {XLEN{1'b0}};
    rs2_val_s = {XLEN{1'b0}};
    if (bus.dec_rs1_en && (bus.dec_rs1_addr != 5'd0)) begin
      rs1_val_s = wb_match(bus.wb_en, bus.wb_addr, bus.dec_rs1_addr) ?
                  bus.wb_data : bus.rf_rs1_data;
    end else begin
      rs1_val_s = {XLEN{1'b0}};
    end
    if (bus.dec_rs2_en && (bus.dec_rs2_addr != 5'd0)) begin
      rs2_val_s = wb_match(bus.wb_en, bus.wb_addr, bus.dec_rs2_addr) ?
                  bus.wb_data : bus.rf_rs2_data;
    end else begin
      rs2_val_s = {XLEN{1'b0}};
    end
  end

  // Scoreboard next state: an issuing write's set outranks any clear.
  always_comb begin
    set_mask_s = (accept_s && rd_write_s) ? (32'd1 << bus.dec_rd_addr) : 32'd0;
    clr_mask_s = ((bus.wb_en && (bus.wb_addr != 5'd0)) ? (32'd1 << bus.wb_addr) : 32'd0)
               | ((bus.kill_en && (bus.kill_addr != 5'd0)) ? (32'd1 << bus.kill_addr) : 32'd0)
               | ((bus.flush && ex_valid_r && ex_rd_we_r) ? (32'd1 << ex_rd_addr_r) : 32'd0);
    pend_next_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Output slot and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r       <= 32'd0;
      ex_valid_r   <= 1'b0;
      ex_pc_r      <= {PC_W{1'b0}};
      ex_imm_r     <= {XLEN{1'b0}};
      ex_rs1_val_r <= {XLEN{1'b0}};
      ex_rs2_val_r <= {XLEN{1'b0}};
      ex_rd_we_r   <= 1'b0;
      ex_rd_addr_r <= 5'd0;
    end else begin
      pend_r <= pend_next_s;
      if (bus.flush) begin
        ex_valid_r <= 1'b0;
      end else if (accept_s) begin
        ex_valid_r   <= 1'b1;
        ex_pc_r      <= bus.dec_pc;
        ex_imm_r     <= bus.dec_imm;
        ex_rs1_val_r <= rs1_val_s;
        ex_rs2_val_r <= rs2_val_s;
        ex_rd_we_r   <= rd_write_s;
        ex_rd_addr_r <= bus.dec_rd_addr;
      end else if (ex_valid_r && bus.ex_ready) begin
        ex_valid_r <= 1'b0;
      end else begin
        ex_valid_r <= ex_valid_r;
      end
    end
  end

  assign bus.dec_ready   = dec_ready_s;
  assign bus.rf_rs1_addr = bus.dec_rs1_addr;
  assign bus.rf_rs2_addr = bus.dec_rs2_addr;
  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_pc       = ex_pc_r;
  assign bus.ex_imm      = ex_imm_r;
  assign bus.ex_rs1_val  = ex_rs1_val_r;
  assign bus.ex_rs2_val  = ex_rs2_val_r;
  assign bus.ex_rd_we    = ex_rd_we_r;
  assign bus.ex_rd_addr  = ex_rd_addr_r;
  assign bus.sb_pending  = pend_r;

endmodule
